// File: rtl/key_matrix_scanner.sv
// Scans a ROWS x COLS passive key matrix with per-key debounce and emits one press/release event per debounced state change.
// Latency: an event rises on the sample edge of the DEBOUNCE-th consecutive mismatching sample of its column.
// Backpressure: the payload holds while keyValid && !keyReady; blocked flip candidates retry on later visits, so no event is lost.
module key_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4,
    localparam int NK = ROWS * COLS,
    localparam int KW = (NK > 1) ? $clog2(NK) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int DW = $clog2(SCAN_DIV)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] rowIn,
    output logic [COLS-1:0] colOut,
    output logic            keyValid,
    input  logic            keyReady,
    output logic [KW-1:0]   keyCode,
    output logic            keyPressed
);

    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   col_idx_q, col_idx_d;
    logic [COLS-1:0] col_out_q, col_out_d;
    logic [NK-1:0]   stable_q, stable_d;
    logic [3:0]      cnt_q [NK];
    logic [3:0]      cnt_d [NK];
    logic            key_valid_q, key_valid_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_pressed_q, key_pressed_d;

    logic sample_edge;
    logic slot_free;
    logic committed;
    logic raw;

    always_comb begin
        sample_edge = (dwell_q == DW'(SCAN_DIV - 1));
        dwell_d     = sample_edge ? '0 : dwell_q + DW'(1);

        col_idx_d = col_idx_q;
        if (sample_edge) begin
            col_idx_d = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + CW'(1);
        end

        // Registered from the current index, so the strobe trails col_idx by one cycle.
        col_out_d = ~(COLS'(1) << col_idx_q);
    end

    always_comb begin
        stable_d      = stable_q;
        cnt_d         = cnt_q;
        slot_free     = !key_valid_q || keyReady;
        committed     = 1'b0;
        raw           = 1'b0;
        key_valid_d   = key_valid_q && !keyReady;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;

        if (sample_edge) begin
            // Keys are visited in ascending index, which within one column is ascending row.
            for (int k = 0; k < NK; k++) begin
                if (col_idx_q == CW'(k % COLS)) begin
                    raw = ~rowIn[k / COLS];
                    if (raw == stable_q[k]) begin
                        cnt_d[k] = '0;
                    end else if (cnt_q[k] < 4'(DEBOUNCE - 1)) begin
                        cnt_d[k] = cnt_q[k] + 4'd1;
                    end else if (slot_free && !committed) begin
                        committed     = 1'b1;
                        stable_d[k]   = raw;
                        cnt_d[k]      = '0;
                        key_valid_d   = 1'b1;
                        key_code_d    = KW'(k);
                        key_pressed_d = raw;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q       <= '0;
            col_idx_q     <= '0;
            col_out_q     <= '1;
            stable_q      <= '0;
            cnt_q         <= '{default: '0};
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            key_pressed_q <= 1'b0;
        end else begin
            dwell_q       <= dwell_d;
            col_idx_q     <= col_idx_d;
            col_out_q     <= col_out_d;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign colOut     = col_out_q;
    assign keyValid   = key_valid_q;
    assign keyCode    = key_code_q;
    assign keyPressed = key_pressed_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a behavioural key matrix driving the row returns.
module tb_key_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEBOUNCE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rowIn;
    logic [3:0]  colOut;
    logic        keyValid;
    logic        keyReady = 1'b1;
    logic [3:0]  keyCode;
    logic        keyPressed;
    logic [15:0] key_down = '0;

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    key_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .reset(reset), .rowIn(rowIn), .colOut(colOut),
        .keyValid(keyValid), .keyReady(keyReady), .keyCode(keyCode), .keyPressed(keyPressed)
    );

    always #5 clk = ~clk;

    // Edge counter: after the n-th non-reset edge, cyc == n.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Passive matrix: a closed key pulls its row low while its column is strobed.
    always_comb begin
        rowIn = 4'b1111;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (key_down[r*COLS+c] && !colOut[c]) rowIn[r] = 1'b0;
    end

    task automatic do_reset();
        reset = 1'b1;
        keyReady = 1'b1;
        key_down = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit seen, output int at);
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (keyValid) begin
                seen = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        keyReady = 1'b1;
        key_down = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (colOut !== 4'b1111) begin fails++; $display("FAIL reset_colOut: got %b expected 1111", colOut); end
        checks++; if (keyValid !== 1'b0) begin fails++; $display("FAIL reset_keyValid: got %b expected 0", keyValid); end
        checks++; if (keyCode !== 4'd0) begin fails++; $display("FAIL reset_keyCode: got %0d expected 0", keyCode); end
        checks++; if (keyPressed !== 1'b0) begin fails++; $display("FAIL reset_keyPressed: got %b expected 0", keyPressed); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_col;
        logic [3:0] one;
        int rises;
        one = 4'b0001;
        rises = 0;
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            exp_col = ~(one << (((n - 1) / 8) % 4));
            checks++;
            if (colOut !== exp_col) begin
                fails++;
                $display("FAIL scan_colOut cycle %0d: got %b expected %b", n, colOut, exp_col);
            end
            if (keyValid) rises++;
        end
        checks++; if (rises !== 0) begin fails++; $display("FAIL scan_no_event: got %0d events expected 0", rises); end
    endtask

    task automatic test_single_key();
        bit seen;
        int at;
        do_reset();
        key_down[9] = 1'b1;
        wait_valid(200, seen, at);
        checks++; if (at !== 80) begin fails++; $display("FAIL press9_cycle: got %0d expected 80", at); end
        checks++; if (keyCode !== 4'd9) begin fails++; $display("FAIL press9_code: got %0d expected 9", keyCode); end
        checks++; if (keyPressed !== 1'b1) begin fails++; $display("FAIL press9_pressed: got %b expected 1", keyPressed); end
        key_down[9] = 1'b0;
        @(negedge clk);
        checks++; if (keyValid !== 1'b0) begin fails++; $display("FAIL press9_pulse: got %b expected 0", keyValid); end
        wait_valid(200, seen, at);
        checks++; if (at !== 176) begin fails++; $display("FAIL release9_cycle: got %0d expected 176", at); end
        checks++; if (keyCode !== 4'd9) begin fails++; $display("FAIL release9_code: got %0d expected 9", keyCode); end
        checks++; if (keyPressed !== 1'b0) begin fails++; $display("FAIL release9_pressed: got %b expected 0", keyPressed); end
    endtask

    task automatic test_bounce();
        int events;
        int first;
        logic [3:0] code;
        logic pr;
        events = 0;
        first = -1;
        code = '0;
        pr = 1'b0;
        do_reset();
        key_down[3] = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            @(negedge clk);
            if (keyValid && keyReady) begin
                events++;
                if (first < 0) begin
                    first = cyc;
                    code = keyCode;
                    pr = keyPressed;
                end
            end
            key_down[3] = (cyc < 70) || (cyc >= 100);
        end
        checks++; if (events !== 1) begin fails++; $display("FAIL bounce_events: got %0d expected 1", events); end
        checks++; if (first !== 192) begin fails++; $display("FAIL bounce_cycle: got %0d expected 192", first); end
        checks++; if (code !== 4'd3) begin fails++; $display("FAIL bounce_code: got %0d expected 3", code); end
        checks++; if (pr !== 1'b1) begin fails++; $display("FAIL bounce_pressed: got %b expected 1", pr); end
    endtask

    task automatic test_simultaneous();
        bit seen;
        int at;
        do_reset();
        key_down[4] = 1'b1;
        key_down[12] = 1'b1;
        wait_valid(200, seen, at);
        checks++; if (at !== 72) begin fails++; $display("FAIL simul_first_cycle: got %0d expected 72", at); end
        checks++; if ({keyCode, keyPressed} !== {4'd4, 1'b1}) begin fails++; $display("FAIL simul_first_payload: got code %0d pressed %b expected code 4 pressed 1", keyCode, keyPressed); end
        wait_valid(200, seen, at);
        checks++; if (at !== 104) begin fails++; $display("FAIL simul_second_cycle: got %0d expected 104", at); end
        checks++; if ({keyCode, keyPressed} !== {4'd12, 1'b1}) begin fails++; $display("FAIL simul_second_payload: got code %0d pressed %b expected code 12 pressed 1", keyCode, keyPressed); end
    endtask

    task automatic test_backpressure();
        bit seen;
        int at;
        int accepts;
        int hold_bad;
        int second_at;
        logic [3:0] second_code;
        hold_bad = 0;
        second_at = -1;
        second_code = '0;
        do_reset();
        keyReady = 1'b0;
        key_down[4] = 1'b1;
        key_down[12] = 1'b1;
        wait_valid(200, seen, at);
        checks++; if (at !== 72) begin fails++; $display("FAIL bp_first_cycle: got %0d expected 72", at); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({keyValid, keyCode, keyPressed} !== {1'b1, 4'd4, 1'b1}) hold_bad++;
        end
        checks++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", hold_bad); end
        keyReady = 1'b1;
        accepts = keyValid ? 1 : 0;
        @(negedge clk);
        checks++; if (keyValid !== 1'b0) begin fails++; $display("FAIL bp_drop_after_accept: got %b expected 0", keyValid); end
        for (int i = 0; i < 87; i++) begin
            @(negedge clk);
            if (keyValid && keyReady) begin
                accepts++;
                second_at = cyc;
                second_code = keyCode;
            end
        end
        checks++; if (accepts !== 2) begin fails++; $display("FAIL bp_total_events: got %0d expected 2", accepts); end
        checks++; if (second_at !== 200) begin fails++; $display("FAIL bp_second_cycle: got %0d expected 200", second_at); end
        checks++; if (second_code !== 4'd12) begin fails++; $display("FAIL bp_second_code: got %0d expected 12", second_code); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int at;
        int rises;
        rises = 0;
        do_reset();
        key_down[5] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (keyValid) rises++;
        end
        checks++; if (rises !== 0) begin fails++; $display("FAIL mid_early_event: got %0d events expected 0", rises); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({colOut, keyValid, keyCode, keyPressed} !== {4'b1111, 1'b0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL mid_reset_values: got colOut %b valid %b code %0d pressed %b expected 1111 0 0 0", colOut, keyValid, keyCode, keyPressed);
        end
        reset = 1'b0;
        keyReady = 1'b0;
        wait_valid(200, seen, at);
        checks++; if (at !== 80) begin fails++; $display("FAIL mid_press_cycle: got %0d expected 80", at); end
        checks++; if ({keyCode, keyPressed} !== {4'd5, 1'b1}) begin fails++; $display("FAIL mid_press_payload: got code %0d pressed %b expected code 5 pressed 1", keyCode, keyPressed); end
        // Reset while the event is still pending must discard it.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({keyValid, keyCode} !== {1'b0, 4'd0}) begin fails++; $display("FAIL mid_pending_lost: got valid %b code %0d expected 0 0", keyValid, keyCode); end
        key_down = '0;
        keyReady = 1'b1;
        reset = 1'b0;
        wait_valid(100, seen, at);
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_ghost_event: got event at %0d expected none", at); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_key();
        test_bounce();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
